// File: rtl/gpu_cmd_if.sv
// Host command port and workgroup launch port of the GPU command processor.
// The slave side is the command processor; the master side is the host /
// shader array that feeds commands and accepts launches.
interface gpu_cmd_if #(
  parameter int NUM_SHADER_CORES = 16
);
  localparam int CORE_W = $clog2(NUM_SHADER_CORES);

  logic [63:0]       host_cmd_data;
  logic              host_cmd_valid;
  logic              host_cmd_ready;
  logic              wg_launch;
  logic              wg_ready;
  logic [CORE_W-1:0] wg_core;
  logic [15:0]       wg_id;
  logic [31:0]       wg_pc;

  modport slave (
    input  host_cmd_data, host_cmd_valid, wg_ready,
    output host_cmd_ready, wg_launch, wg_core, wg_id, wg_pc
  );

  modport master (
    output host_cmd_data, host_cmd_valid, wg_ready,
    input  host_cmd_ready, wg_launch, wg_core, wg_id, wg_pc
  );
endinterface

// File: rtl/gpu_cmd_processor.sv
// GPU front-end command processor: buffers host command words in a FIFO,
// decodes them in order, expands DISPATCH into round-robin workgroup
// launches and holds FENCE until every shader core reports idle.
module gpu_cmd_processor #(
  parameter int NUM_SHADER_CORES = 16,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                        clk_2GHz,
  input  logic                        rst_n,
  gpu_cmd_if.slave                    cmd,
  input  logic [NUM_SHADER_CORES-1:0] shader_busy,
  output logic                        fence_done,
  output logic [1:0]                  cp_state,
  output logic [15:0]                 cmds_retired,
  output logic                        err_opcode
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int CORE_W = $clog2(NUM_SHADER_CORES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_DISPATCH = 2'b01,
    S_FENCE    = 2'b10
  } state_t;

  state_t            state;
  logic [63:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic [63:0]       head;
  logic [3:0]        head_op;
  logic [15:0]       head_n;
  logic [31:0]       pc_reg;
  logic [CORE_W-1:0] rr_ptr;
  logic [15:0]       wg_n;
  logic              wg_launch_r;
  logic [15:0]       wg_id_r;
  logic [31:0]       wg_pc_r;
  logic              hs;
  logic              retire;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never re-opens a full FIFO until the following edge.
  assign cmd.host_cmd_ready = (count != CW'(FIFO_DEPTH));
  assign push    = cmd.host_cmd_valid && cmd.host_cmd_ready;
  assign pop     = (state == S_IDLE) && (count != '0);
  assign head    = fifo_mem[rd_ptr];
  assign head_op = head[63:60];
  assign head_n  = head[15:0];
  assign hs      = wg_launch_r && cmd.wg_ready;

  assign cmd.wg_launch = wg_launch_r;
  assign cmd.wg_core   = rr_ptr;
  assign cmd.wg_id     = wg_id_r;
  assign cmd.wg_pc     = wg_pc_r;
  assign cp_state      = state;

  // Decide whether the current cycle completes a command.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_IDLE:     retire = pop && (head_op != 4'h3) &&
                           !((head_op == 4'h2) && (head_n != 16'd0));
      S_DISPATCH: retire = hs && (wg_id_r == wg_n - 16'd1);
      S_FENCE:    retire = fence_done;
      default:    retire = 1'b0;
    endcase
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk_2GHz) begin
    if (push) fifo_mem[wr_ptr] <= cmd.host_cmd_data;
  end

  // FIFO pointers and occupancy; reset flushes all buffered commands.
  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Decode/dispatch/fence state machine with registered outputs.
  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc_reg       <= '0;
      rr_ptr       <= '0;
      wg_n         <= '0;
      wg_launch_r  <= 1'b0;
      wg_id_r      <= '0;
      wg_pc_r      <= '0;
      fence_done   <= 1'b0;
      cmds_retired <= '0;
      err_opcode   <= 1'b0;
    end else begin
      fence_done <= 1'b0;
      if (retire) cmds_retired <= cmds_retired + 16'd1;
      case (state)
        S_IDLE: begin
          if (pop) begin
            case (head_op)
              4'h0: ;
              4'h1: pc_reg <= head[31:0];
              4'h2: begin
                if (head_n != 16'd0) begin
                  wg_n        <= head_n;
                  wg_pc_r     <= pc_reg;
                  wg_id_r     <= '0;
                  wg_launch_r <= 1'b1;
                  state       <= S_DISPATCH;
                end
              end
              4'h3: begin
                // Pulse is raised one cycle after sampling idle cores, while
                // still reporting the FENCE state.
                fence_done <= (shader_busy == '0);
                state      <= S_FENCE;
              end
              default: err_opcode <= 1'b1;
            endcase
          end
        end
        S_DISPATCH: begin
          if (hs) begin
            rr_ptr <= rr_ptr + CORE_W'(1);
            if (wg_id_r == wg_n - 16'd1) begin
              wg_launch_r <= 1'b0;
              state       <= S_IDLE;
            end else begin
              wg_id_r <= wg_id_r + 16'd1;
            end
          end
        end
        S_FENCE: begin
          if (fence_done) state <= S_IDLE;
          else            fence_done <= (shader_busy == '0);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
